// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM state type and counter sizing for the divider (DIVIDER_SIGNED_EN aware)
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to count 0..bits inclusive, i.e. clog2(bits+1).
    function automatic int cnt_width(input int bits);
        int w;
        w = 1;
        while ((1 << w) < (bits + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division step
module divider_step
    import divider_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] i_rem,
    input  logic            i_bit,
    input  logic [BITS-1:0] i_divisor,
    output logic [BITS-1:0] o_rem,
    output logic            o_qbit
);

    logic [BITS:0] w_shift;
    logic [BITS:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // The incoming remainder is always below the divisor, so the borrow bit alone
    // tells whether shift >= divisor; a non-borrowing difference fits in BITS bits.
    assign o_qbit = ~w_diff[BITS];
    assign o_rem  = o_qbit ? w_diff[BITS-1:0] : w_shift[BITS-1:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring divider top; DIVIDER_SIGNED_EN selects two's-complement operands
module divider
    import divider_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [BITS-1:0] i_dividend,
    input  logic [BITS-1:0] i_divisor,
    output logic [BITS-1:0] o_quotient,
    output logic [BITS-1:0] o_remainder,
    output logic            o_finished,
    output logic            o_busy,
    output logic            o_div_by_zero
);

    localparam int CW = cnt_width(BITS);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BITS-1:0] r_rem;
    logic [BITS-1:0] r_dvd;
    logic [BITS-1:0] r_dvs;
    logic [BITS-1:0] r_quo;
    logic            r_finished;
    logic            r_dbz;

    logic [BITS-1:0] w_rem_next;
    logic            w_qbit;
    logic [BITS-1:0] w_dvd_in;
    logic [BITS-1:0] w_dvs_in;

`ifdef DIVIDER_SIGNED_EN
    logic            r_neg_q;
    logic            r_neg_r;
    logic [BITS-1:0] r_raw_dvd;

    assign w_dvd_in = i_dividend[BITS-1] ? -i_dividend : i_dividend;
    assign w_dvs_in = i_divisor[BITS-1]  ? -i_divisor  : i_divisor;
`else
    assign w_dvd_in = i_dividend;
    assign w_dvs_in = i_divisor;
`endif

    divider_step #(.BITS(BITS)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[BITS-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_quo      <= '0;
            r_finished <= 1'b0;
            r_dbz      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_raw_dvd  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_dvd      <= w_dvd_in;
                        r_dvs      <= w_dvs_in;
                        r_quo      <= '0;
                        r_finished <= 1'b0;
                        r_dbz      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        r_neg_q    <= i_dividend[BITS-1] ^ i_divisor[BITS-1];
                        r_neg_r    <= i_dividend[BITS-1];
                        r_raw_dvd  <= i_dividend;
`endif
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[BITS-2:0], w_qbit};
                    r_dvd <= {r_dvd[BITS-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(BITS - 1)) begin
                        r_state    <= ST_DONE;
                        r_finished <= 1'b1;
                        r_dbz      <= (r_dvs == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DIVIDER_SIGNED_EN
    // Zero divisor reports the raw core result; otherwise apply the sign fixup.
    assign o_quotient  = (r_neg_q && !r_dbz) ? -r_quo : r_quo;
    assign o_remainder = r_dbz ? r_raw_dvd : (r_neg_r ? -r_rem : r_rem);
`else
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
`endif

    assign o_finished    = r_finished;
    assign o_busy        = (r_state == ST_RUN);
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider (vectors, corner sequences, random vs model)
module tb_divider;

    localparam int BITS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       fin;
    logic       busy;
    logic       dbz;

    always #1 clk = ~clk;

    divider #(.BITS(BITS)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_dividend    (a),
        .i_divisor     (b),
        .o_quotient    (q),
        .o_remainder   (r),
        .o_finished    (fin),
        .o_busy        (busy),
        .o_div_by_zero (dbz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [3:0] x, input logic [3:0] y,
                                    output logic [3:0] eq, output logic [3:0] er,
                                    output logic edz);
        int sx;
        int sy;
        sx = 0;
        sy = 0;
        if (y == 4'd0) begin
            eq  = 4'hF;
            er  = x;
            edz = 1'b1;
        end else begin
            edz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sx = $signed(x);
            sy = $signed(y);
            eq = 4'(sx / sy);
            er = 4'(sx % sy);
`else
            sx = int'(x);
            sy = int'(y);
            eq = 4'(sx / sy);
            er = 4'(sx % sy);
`endif
        end
    endfunction

    // One division with start pulsed for a single cycle; optional stray start at RUN cycle `glitch`.
    task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int glitch);
        int lat;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, int'({busy, fin}), 2);
        lat = 0;
        while (!fin && lat < 20) begin
            if (glitch != 0 && lat == glitch) begin
                start = 1'b1;
                a = x ^ 4'h5;
                b = y ^ 4'h3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 4);
        check({tag, "_q"}, int'(q), int'(eq));
        check({tag, "_r"}, int'(r), int'(er));
        check({tag, "_dz"}, int'(dbz), int'(edz));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, int'({fin, q, r}), int'({1'b1, eq, er}));
    endtask

    initial begin
        logic [3:0] eq;
        logic [3:0] er;
        logic       edz;
        logic [3:0] ha[3];
        logic [3:0] hb[3];
        int         idx;
        int         cyc;
        int         last;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({q, r, fin, busy, dbz}), 0);
        rst_n = 1'b1;

`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{4'd9,  4'd2,  4'd13, 4'd15, 1'b0});
        vecs.push_back('{4'd8,  4'd15, 4'd8,  4'd0,  1'b0});
        vecs.push_back('{4'd7,  4'd0,  4'd15, 4'd7,  1'b1});
        vecs.push_back('{4'd11, 4'd0,  4'd15, 4'd11, 1'b1});
        vecs.push_back('{4'd7,  4'd14, 4'd13, 4'd1,  1'b0});
        vecs.push_back('{4'd8,  4'd3,  4'd14, 4'd14, 1'b0});
`else
        vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1,  1'b0});
        vecs.push_back('{4'd7,  4'd0,  4'd15, 4'd7,  1'b1});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
        vecs.push_back('{4'd9,  4'd4,  4'd2,  4'd1,  1'b0});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
        vecs.push_back('{4'd1,  4'd15, 4'd0,  4'd1,  1'b0});
`endif
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].dz, 0);
        end

        // Start held high across three back-to-back operations.
        ha[0] = 4'd15; hb[0] = 4'd1;
        ha[1] = 4'd9;  hb[1] = 4'd4;
        ha[2] = 4'd0;  hb[2] = 4'd5;
        @(negedge clk);
        a = ha[0];
        b = hb[0];
        start = 1'b1;
        @(posedge clk);
        idx  = 0;
        cyc  = 0;
        last = 0;
        while (idx < 3 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (fin) begin
                ref_div(ha[idx], hb[idx], eq, er, edz);
                check($sformatf("held%0d_gap", idx), cyc - last, (idx == 0) ? 4 : 5);
                check($sformatf("held%0d_qr", idx), int'({q, r}), int'({eq, er}));
                last = cyc;
                idx++;
                if (idx < 3) begin
                    a = ha[idx];
                    b = hb[idx];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_count", idx, 3);

        // Stray start two cycles into RUN must not disturb the running op.
        ref_div(4'd10, 4'd3, eq, er, edz);
        run_op("ignore_start", 4'd10, 4'd3, eq, er, edz, 2);

        // Reset in the middle of RUN.
        @(negedge clk);
        a = 4'd11;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset", int'({q, r, fin, busy, dbz}), 0);
        rst_n = 1'b1;
        run_op("after_reset", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            logic [3:0] x;
            logic [3:0] y;
            x = 4'($urandom_range(0, 15));
            y = (k % 7 == 3) ? 4'd0 : 4'($urandom_range(0, 15));
            ref_div(x, y, eq, er, edz);
            run_op($sformatf("rand%0d_%0d_%0d", k, x, y), x, y, eq, er, edz, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
